// File: rtl/csr_test_monitor.sv
// rtl/csr_test_monitor.sv - end-of-test monitor that latches per-channel CSR results and issues a pass/fail/timeout verdict
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset; starts a fresh test on release
//   csr_we     per-channel result write strobe
//   csr_wdata  per-channel result data, channel i at [i*CSR_W +: CSR_W]
//   ch_valid   channel has latched its (first nonzero) result
//   ch_pass    channel's latched result equals 1
//   busy       in SETTLE, RUN or DRAIN
//   done       in DONE; verdict outputs are meaningful
//   pass/fail/timeout  registered verdict, at most one high, low until done
//   fail_ch    lowest-index failing channel (0 when none)
//   fail_code  failing channel's latched data[CSR_W-1:1] (0 when none)
//   cycles     cycles since reset release, saturating, frozen from DRAIN entry
module csr_test_monitor #(
  parameter int NUM_CH         = 1,
  parameter int CSR_W          = 32,
  parameter int SETTLE_CYCLES  = 10,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int DRAIN_CYCLES   = 100,
  parameter int CYC_W          = 32,
  parameter int STOP_ON_FAIL   = 1,
  localparam int FCH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       csr_we,
  input  logic [NUM_CH*CSR_W-1:0] csr_wdata,
  output logic [NUM_CH-1:0]       ch_valid,
  output logic [NUM_CH-1:0]       ch_pass,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic                    fail,
  output logic                    timeout,
  output logic [FCH_W-1:0]        fail_ch,
  output logic [CSR_W-2:0]        fail_code,
  output logic [CYC_W-1:0]        cycles
);

  typedef enum logic [1:0] {
    S_SETTLE = 2'd0,
    S_RUN    = 2'd1,
    S_DRAIN  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t state, state_nx;

  // One phase counter serves settle, run-timeout and drain; cleared on every transition.
  logic [31:0]      phase_cnt;
  logic             phase_clr;
  logic             run_to;
  logic             timed_out;

  // Only the code bits are stored; pass/fail of a latched result lives in ch_pass.
  logic [CSR_W-2:0] code_q  [NUM_CH];
  logic [CSR_W-2:0] code_nx [NUM_CH];
  logic [NUM_CH-1:0] cap, valid_nx, fail_nx;
  logic             complete;
  logic [FCH_W-1:0] fsel;
  logic [CSR_W-2:0] fcode;

  // Capture decode and post-capture view, so same-cycle writes count toward completion.
  always_comb begin
    cap      = '0;
    fail_nx  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cap[i]     = (state == S_RUN) && csr_we[i] && !ch_valid[i] &&
                   (csr_wdata[i*CSR_W +: CSR_W] != '0);
      fail_nx[i] = cap[i] ? (csr_wdata[i*CSR_W +: CSR_W] != CSR_W'(1))
                          : (ch_valid[i] && !ch_pass[i]);
      code_nx[i] = cap[i] ? csr_wdata[i*CSR_W+1 +: CSR_W-1] : code_q[i];
    end
    valid_nx = ch_valid | cap;
    complete = (&valid_nx) || ((STOP_ON_FAIL != 0) && (|fail_nx));
  end

  // Lowest failing index wins: scan downward so the last hit is the lowest.
  always_comb begin
    fsel  = '0;
    fcode = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (fail_nx[i]) begin
        fsel  = FCH_W'(i);
        fcode = code_nx[i];
      end
    end
  end

  always_comb begin
    state_nx  = state;
    phase_clr = 1'b0;
    run_to    = 1'b0;
    case (state)
      S_SETTLE: begin
        if (phase_cnt == 32'(SETTLE_CYCLES - 1)) begin
          state_nx  = S_RUN;
          phase_clr = 1'b1;
        end
      end
      S_RUN: begin
        if (complete || (phase_cnt == 32'(TIMEOUT_CYCLES - 1))) begin
          // Completion on the timeout cycle takes precedence.
          run_to    = !complete;
          state_nx  = (DRAIN_CYCLES == 0) ? S_DONE : S_DRAIN;
          phase_clr = 1'b1;
        end
      end
      S_DRAIN: begin
        if (phase_cnt == 32'(DRAIN_CYCLES - 1)) begin
          state_nx  = S_DONE;
          phase_clr = 1'b1;
        end
      end
      default: begin
        phase_clr = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_SETTLE;
      phase_cnt <= '0;
      timed_out <= 1'b0;
      ch_valid  <= '0;
      ch_pass   <= '0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      timeout   <= 1'b0;
      fail_ch   <= '0;
      fail_code <= '0;
      cycles    <= '0;
      for (int i = 0; i < NUM_CH; i++) code_q[i] <= '0;
    end else begin
      state     <= state_nx;
      phase_cnt <= phase_clr ? 32'd0 : phase_cnt + 32'd1;
      if (((state == S_SETTLE) || (state == S_RUN)) && (cycles != '1))
        cycles <= cycles + 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
        if (cap[i]) begin
          ch_valid[i] <= 1'b1;
          ch_pass[i]  <= (csr_wdata[i*CSR_W +: CSR_W] == CSR_W'(1));
          code_q[i]   <= csr_wdata[i*CSR_W+1 +: CSR_W-1];
        end
      end
      if (run_to) timed_out <= 1'b1;
      if ((state_nx == S_DONE) && (state != S_DONE)) begin
        timeout   <= timed_out || run_to;
        fail      <= !(timed_out || run_to) && (|fail_nx);
        pass      <= !(timed_out || run_to) && !(|fail_nx);
        fail_ch   <= fsel;
        fail_code <= fcode;
      end
    end
  end

  assign busy = (state != S_DONE);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_csr_test_monitor.sv
// tb/tb_csr_test_monitor.sv - self-checking bench for csr_test_monitor with three parameterisations
//
// DUT 0: 4 channels, stop on fail, settle 10, timeout 20, drain 3
// DUT 1: 2 channels, run to completion, settle 3, timeout 20, drain 0, 4-bit cycle counter
// DUT 2: 1 channel, settle 10, timeout 100, drain 4
module tb_csr_test_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_v [3];
  logic [3:0] we_v  [3];
  logic [7:0] wd_v  [3][4];

  logic [3:0] v0, pp0;  logic by0, dn0, ps0, fl0, to0;  logic [1:0] fc0;  logic [6:0] fd0;  logic [7:0]  cy0;
  logic [1:0] v1, pp1;  logic by1, dn1, ps1, fl1, to1;  logic [0:0] fc1;  logic [6:0] fd1;  logic [3:0]  cy1;
  logic [0:0] v2, pp2;  logic by2, dn2, ps2, fl2, to2;  logic [0:0] fc2;  logic [6:0] fd2;  logic [31:0] cy2;

  csr_test_monitor #(.NUM_CH(4), .CSR_W(8), .SETTLE_CYCLES(10), .TIMEOUT_CYCLES(20),
                     .DRAIN_CYCLES(3), .CYC_W(8), .STOP_ON_FAIL(1)) dut0 (
    .clk(clk), .rst(rst_v[0]), .csr_we(we_v[0]),
    .csr_wdata({wd_v[0][3], wd_v[0][2], wd_v[0][1], wd_v[0][0]}),
    .ch_valid(v0), .ch_pass(pp0), .busy(by0), .done(dn0), .pass(ps0), .fail(fl0),
    .timeout(to0), .fail_ch(fc0), .fail_code(fd0), .cycles(cy0));

  csr_test_monitor #(.NUM_CH(2), .CSR_W(8), .SETTLE_CYCLES(3), .TIMEOUT_CYCLES(20),
                     .DRAIN_CYCLES(0), .CYC_W(4), .STOP_ON_FAIL(0)) dut1 (
    .clk(clk), .rst(rst_v[1]), .csr_we(we_v[1][1:0]),
    .csr_wdata({wd_v[1][1], wd_v[1][0]}),
    .ch_valid(v1), .ch_pass(pp1), .busy(by1), .done(dn1), .pass(ps1), .fail(fl1),
    .timeout(to1), .fail_ch(fc1), .fail_code(fd1), .cycles(cy1));

  csr_test_monitor #(.NUM_CH(1), .CSR_W(8), .SETTLE_CYCLES(10), .TIMEOUT_CYCLES(100),
                     .DRAIN_CYCLES(4), .CYC_W(32), .STOP_ON_FAIL(1)) dut2 (
    .clk(clk), .rst(rst_v[2]), .csr_we(we_v[2][0:0]),
    .csr_wdata(wd_v[2][0]),
    .ch_valid(v2), .ch_pass(pp2), .busy(by2), .done(dn2), .pass(ps2), .fail(fl2),
    .timeout(to2), .fail_ch(fc2), .fail_code(fd2), .cycles(cy2));

  int p_nch     [3] = '{4, 2, 1};
  int p_settle  [3] = '{10, 3, 10};
  int p_timeout [3] = '{20, 20, 100};
  int p_drain   [3] = '{3, 0, 4};
  int p_cw      [3] = '{8, 4, 32};
  int p_stop    [3] = '{1, 0, 1};

  // Model: counts released edges, records the edge where RUN ended, derives everything else.
  int          m_e     [3];
  int          m_end   [3];
  bit          m_ended [3];
  bit          m_to    [3];
  bit          m_vld   [3][4];
  int          m_val   [3][4];
  logic [63:0] x_valid [3], x_chpass [3], x_busy [3], x_done [3], x_pass [3];
  logic [63:0] x_fail  [3], x_timeout [3], x_fch [3], x_fcode [3], x_cyc [3];

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string nm, input int d, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s dut%0d t=%0t: got %0h expected %0h", nm, d, $time, act, exp);
    end
  endtask

  task automatic model_step(input int d);
    bit          was_ended, all_v, any_f, dn;
    int          fidx;
    logic [63:0] cmax;
    cmax = (p_cw[d] >= 64) ? '1 : ((64'd1 << p_cw[d]) - 64'd1);
    if (rst_v[d]) begin
      m_e[d] = 0; m_end[d] = 0; m_ended[d] = 0; m_to[d] = 0; x_cyc[d] = 0;
      for (int c = 0; c < 4; c++) begin m_vld[d][c] = 0; m_val[d][c] = 0; end
    end else begin
      was_ended = m_ended[d];
      if (!m_ended[d] && m_e[d] >= p_settle[d]) begin
        for (int c = 0; c < p_nch[d]; c++)
          if (we_v[d][c] && !m_vld[d][c] && wd_v[d][c] != 0) begin
            m_vld[d][c] = 1; m_val[d][c] = int'(wd_v[d][c]);
          end
        all_v = 1; any_f = 0;
        for (int c = 0; c < p_nch[d]; c++) begin
          all_v &= m_vld[d][c];
          if (m_vld[d][c] && m_val[d][c] != 1) any_f = 1;
        end
        if (all_v || (p_stop[d] != 0 && any_f)) begin
          m_ended[d] = 1; m_end[d] = m_e[d];
        end else if (m_e[d] - p_settle[d] + 1 == p_timeout[d]) begin
          m_ended[d] = 1; m_to[d] = 1; m_end[d] = m_e[d];
        end
      end
      if (!was_ended) x_cyc[d] = (64'(m_e[d] + 1) > cmax) ? cmax : 64'(m_e[d] + 1);
      m_e[d]++;
    end
    dn = m_ended[d] && (m_e[d] - 1 >= m_end[d] + p_drain[d]);
    x_valid[d] = 0; x_chpass[d] = 0; fidx = -1;
    for (int c = 0; c < p_nch[d]; c++) begin
      x_valid[d][c]  = m_vld[d][c];
      x_chpass[d][c] = m_vld[d][c] && m_val[d][c] == 1;
      if (fidx < 0 && m_vld[d][c] && m_val[d][c] != 1) fidx = c;
    end
    x_busy[d]    = !dn;
    x_done[d]    = dn;
    x_timeout[d] = dn && m_to[d];
    x_fail[d]    = dn && !m_to[d] && fidx >= 0;
    x_pass[d]    = dn && !m_to[d] && fidx < 0;
    x_fch[d]     = (dn && fidx >= 0) ? 64'(fidx) : 64'd0;
    x_fcode[d]   = (dn && fidx >= 0) ? 64'(m_val[d][fidx] >> 1) : 64'd0;
  endtask

  initial forever begin
    @(posedge clk);
    for (int d = 0; d < 3; d++) model_step(d);
  end

  initial forever begin
    logic [63:0] a [10];
    @(negedge clk);
    if (chk_en) begin
      for (int d = 0; d < 3; d++) begin
        case (d)
          0: a = '{64'(v0), 64'(pp0), 64'(by0), 64'(dn0), 64'(ps0), 64'(fl0), 64'(to0), 64'(fc0), 64'(fd0), 64'(cy0)};
          1: a = '{64'(v1), 64'(pp1), 64'(by1), 64'(dn1), 64'(ps1), 64'(fl1), 64'(to1), 64'(fc1), 64'(fd1), 64'(cy1)};
          default: a = '{64'(v2), 64'(pp2), 64'(by2), 64'(dn2), 64'(ps2), 64'(fl2), 64'(to2), 64'(fc2), 64'(fd2), 64'(cy2)};
        endcase
        chk("ch_valid", d, a[0], x_valid[d]);
        chk("ch_pass", d, a[1], x_chpass[d]);
        chk("busy", d, a[2], x_busy[d]);
        chk("done", d, a[3], x_done[d]);
        chk("pass", d, a[4], x_pass[d]);
        chk("fail", d, a[5], x_fail[d]);
        chk("timeout", d, a[6], x_timeout[d]);
        chk("fail_ch", d, a[7], x_fch[d]);
        chk("fail_code", d, a[8], x_fcode[d]);
        chk("cycles", d, a[9], x_cyc[d]);
      end
    end
  end

  typedef struct { int t; int ch; int data; } stim_t;
  stim_t stim [$];

  task automatic w(input int t, input int ch, input int data);
    stim_t s;
    s.t = t; s.ch = ch; s.data = data;
    stim.push_back(s);
  endtask

  // Reset DUT d for two edges, then apply the queued writes at released-edge index t.
  task automatic run_test(input int d, input int ncyc);
    rst_v[d] = 1'b1; we_v[d] = '0;
    @(posedge clk); @(posedge clk); #1;
    rst_v[d] = 1'b0;
    for (int k = 0; k < ncyc; k++) begin
      we_v[d] = '0;
      for (int c = 0; c < 4; c++) wd_v[d][c] = '0;
      foreach (stim[j])
        if (stim[j].t == k) begin
          we_v[d][stim[j].ch] = 1'b1;
          wd_v[d][stim[j].ch] = 8'(stim[j].data);
        end
      @(posedge clk); #1;
    end
    we_v[d] = '0;
    stim.delete();
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      rst_v[d] = 1'b1; we_v[d] = '0;
      for (int c = 0; c < 4; c++) wd_v[d][c] = '0;
    end
    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1;
    chk("lit_reset_busy", 0, 64'(by0), 64'd1);
    chk("lit_reset_cycles", 0, 64'(cy0), 64'd0);

    // Single channel: write 1 at cycle 50 -> pass, cycles 51.
    w(50, 0, 1);
    run_test(2, 70);
    chk("lit_single_pass", 2, x_pass[2], 64'd1);
    chk("lit_single_cycles", 2, x_cyc[2], 64'd51);

    // Stop on fail: settle-time write ignored, zero write ignored, ch2 writes 7.
    w(2, 0, 1); w(15, 2, 7); w(15, 1, 0);
    run_test(0, 30);
    chk("lit_stop_fail", 0, x_fail[0], 64'd1);
    chk("lit_stop_fail_ch", 0, x_fch[0], 64'd2);
    chk("lit_stop_fail_code", 0, x_fcode[0], 64'd3);
    chk("lit_stop_valid", 0, x_valid[0], 64'h4);

    // Two channels reporting in the same cycle, one failing.
    w(12, 0, 1); w(12, 3, 9);
    run_test(0, 25);
    chk("lit_multi_valid", 0, x_valid[0], 64'h9);
    chk("lit_multi_fail_ch", 0, x_fch[0], 64'd3);

    // Last channel reports on the timeout cycle; rewrite of a latched channel ignored.
    w(11, 0, 1); w(11, 1, 1); w(14, 1, 5); w(16, 2, 1); w(29, 3, 1);
    run_test(0, 40);
    chk("lit_edge_pass", 0, x_pass[0], 64'd1);
    chk("lit_edge_timeout", 0, x_timeout[0], 64'd0);
    chk("lit_edge_cycles", 0, x_cyc[0], 64'd30);

    // Only a settle-time write: timeout after 20 RUN cycles.
    w(5, 0, 1);
    run_test(0, 40);
    chk("lit_to_timeout", 0, x_timeout[0], 64'd1);
    chk("lit_to_cycles", 0, x_cyc[0], 64'd30);

    // Run to completion: ch0 fails early, DRAIN only after ch1.
    w(5, 0, 5); w(12, 1, 1);
    run_test(1, 20);
    chk("lit_all_fail", 1, x_fail[1], 64'd1);
    chk("lit_all_fail_code", 1, x_fcode[1], 64'd2);
    chk("lit_all_cycles", 1, x_cyc[1], 64'd13);

    // Timeout with a saturating 4-bit cycle counter.
    w(4, 0, 1);
    run_test(1, 30);
    chk("lit_sat_cycles", 1, x_cyc[1], 64'd15);
    chk("lit_sat_timeout", 1, x_timeout[1], 64'd1);

    // Reset mid-RUN, then a fresh test where all channels pass at once.
    w(12, 0, 1);
    run_test(0, 15);
    chk("lit_mid_valid", 0, x_valid[0], 64'h1);
    w(10, 0, 1); w(10, 1, 1); w(10, 2, 1); w(10, 3, 1);
    run_test(0, 20);
    chk("lit_fresh_pass", 0, x_pass[0], 64'd1);
    chk("lit_fresh_cycles", 0, x_cyc[0], 64'd11);

    @(negedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
